fetch_stage: RTL

Y86-64 pipeline fetch stage. It holds the F pipeline register (predicted PC), selects the fetch PC, reads a byte-addressable instruction memory, and splits and aligns the instruction. It also computes valP, the next predicted PC and the fetch status. All f_* outputs are combinational within the cycle and feed the D pipeline register directly downstream. The instruction memory is loaded through a synchronous write port before or during execution.

---
 rtl/fetch_stage.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: F register, PC select, byte-wide instruction memory,
// instruction split/align, valP / predicted-PC generation and fetch status.
module fetch_stage #(
   parameter int          MEM_BYTES = 1024,
   parameter logic [63:0] RESET_PC  = 64'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        F_stall,
   input  logic [3:0]  M_icode,
   input  logic        M_Cnd,
   input  logic [63:0] M_valA,
   input  logic [3:0]  W_icode,
   input  logic [63:0] W_valM,
   input  logic        ld_en,
   input  logic [63:0] ld_addr,
   input  logic [7:0]  ld_data,
   output logic [63:0] F_predPC,
   output logic [63:0] f_pc,
   output logic [3:0]  f_icode,
   output logic [3:0]  f_ifun,
   output logic [3:0]  f_rA,
   output logic [3:0]  f_rB,
   output logic [63:0] f_valC,
   output logic [63:0] f_valP,
   output logic [63:0] f_predPC,
   output logic [2:0]  f_stat
);

   localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
   localparam logic [64:0] LIM = 65'(MEM_BYTES);

   localparam logic [2:0] S_AOK = 3'd1;
   localparam logic [2:0] S_HLT = 3'd2;
   localparam logic [2:0] S_ADR = 3'd3;
   localparam logic [2:0] S_INS = 3'd4;

   logic [7:0]  mem [MEM_BYTES];
   logic [7:0]  b0;
   logic [7:0]  b1;
   logic [3:0]  icode;
   logic [3:0]  ifun;
   logic        need_regids;
   logic        need_valc;
   logic        instr_valid;
   logic        imem_error;
   logic [63:0] cbase;
   logic [63:0] valc;
   logic [64:0] last;

   // Out-of-range reads return zero; imem_error flags them separately.
   function automatic logic [7:0] rd(input logic [63:0] a);
      if ({1'b0, a} < LIM) return mem[a[AW-1:0]];
      return 8'h00;
   endfunction

   always_ff @(posedge clk) begin
      if (ld_en && ({1'b0, ld_addr} < LIM))
         mem[ld_addr[AW-1:0]] <= ld_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         F_predPC <= RESET_PC;
      else if (!F_stall)
         F_predPC <= f_predPC;
   end

   // Mispredicted branch outranks a returning ret.
   always_comb begin
      if (M_icode == 4'h7 && !M_Cnd)
         f_pc = M_valA;
      else if (W_icode == 4'h9)
         f_pc = W_valM;
      else
         f_pc = F_predPC;
   end

   always_comb begin
      b0 = rd(f_pc);
      icode = b0[7:4];
      ifun = b0[3:0];
      need_regids = icode inside {4'h2, 4'h3, 4'h4, 4'h5,
                                  4'h6, 4'hA, 4'hB};
      need_valc = icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
      b1 = rd(f_pc + 64'd1);
      cbase = f_pc + 64'd1 + {63'd0, need_regids};
      valc = '0;
      for (int k = 0; k < 8; k++)
         valc[8*k +: 8] = rd(cbase + 64'(k));
      if (!need_valc)
         valc = '0;
      f_valP = f_pc + 64'd1 + {63'd0, need_regids}
             + {60'd0, need_valc, 3'b000};
      // Address of the last byte, one bit wider so it never wraps.
      last = {1'b0, f_pc} + {64'd0, need_regids}
           + {61'd0, need_valc, 3'b000};
      imem_error = (last >= LIM);

      unique case (icode)
         4'h2, 4'h7: instr_valid = (ifun <= 4'd6);
         4'h6:       instr_valid = (ifun <= 4'd3);
         4'h0, 4'h1, 4'h3, 4'h4, 4'h5,
         4'h8, 4'h9, 4'hA, 4'hB:
                     instr_valid = (ifun == 4'd0);
         default:    instr_valid = 1'b0;
      endcase

      f_icode = icode;
      f_ifun = ifun;
      f_rA = need_regids ? b1[7:4] : 4'hF;
      f_rB = need_regids ? b1[3:0] : 4'hF;
      f_valC = valc;
      f_stat = S_AOK;
      if (imem_error) begin
         f_stat = S_ADR;
         f_icode = 4'h1;
         f_ifun = 4'h0;
         f_rA = 4'hF;
         f_rB = 4'hF;
         f_valC = '0;
      end else if (!instr_valid) begin
         f_stat = S_INS;
      end else if (icode == 4'h0) begin
         f_stat = S_HLT;
      end

      if (f_icode == 4'h7 || f_icode == 4'h8)
         f_predPC = f_valC;
      else
         f_predPC = f_valP;
   end

endmodule
